// File: rtl/mux_scan_n.sv
// -----------------------------------------------------------------------------
// mux_scan_n
//   Parametrised N_CH-channel, WIDTH-bit registered multiplexer with a manual
//   select mode and an auto-scan mode. Auto-scan steps round-robin through the
//   enabled channels and dwells DWELL clock cycles on each one.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       synchronous reset, active-low
//   din_i        packed channel data, channel k = din_i[k*WIDTH +: WIDTH]
//   mode_i       0 = manual (sel_i), 1 = auto-scan
//   sel_i        manual channel select (out-of-range values are ignored)
//   en_mask_i    scan-mode channel enables
//   hold_i       scan-mode freeze of channel and dwell counter
//   dout_o       registered data of the selected channel
//   cur_ch_o     channel currently driving dout_o
//   ch_change_o  one-cycle pulse when cur_ch_o changes
//   all_off_o    registered, 1 while scanning with en_mask_i == 0
// -----------------------------------------------------------------------------
module mux_scan_n #(
   parameter int N_CH  = 4,
   parameter int WIDTH = 1,
   parameter int SEL_W = 2,
   parameter int DWELL = 15
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [N_CH*WIDTH-1:0]   din_i,
   input  logic                    mode_i,
   input  logic [SEL_W-1:0]        sel_i,
   input  logic [N_CH-1:0]         en_mask_i,
   input  logic                    hold_i,
   output logic [WIDTH-1:0]        dout_o,
   output logic [SEL_W-1:0]        cur_ch_o,
   output logic                    ch_change_o,
   output logic                    all_off_o
);

   // A one-cycle dwell still needs a one-bit counter to keep the logic uniform.
   localparam int DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DCNT_W-1:0] DWELL_LAST = DCNT_W'(DWELL - 1);

   logic [WIDTH-1:0]  dout_q,      dout_d;
   logic [SEL_W-1:0]  cur_ch_q;
   logic              ch_change_q, ch_change_d;
   logic              all_off_q,   all_off_d;
   logic [DCNT_W-1:0] dwell_q,     dwell_d;
   logic [SEL_W-1:0]  nxt_ch_s;
   logic              cur_en_s;

   // Next enabled channel strictly above cur (wrapping). Returns cur when it is
   // the only enabled channel, and cur when no channel is enabled at all.
   function automatic logic [SEL_W-1:0] next_enabled(input logic [SEL_W-1:0] cur,
                                                     input logic [N_CH-1:0]  mask);
      logic [SEL_W-1:0] res;
      logic             found;
      int               idx;
      res   = cur;
      found = 1'b0;
      for (int k = 1; k <= N_CH; k++) begin
         idx = (int'(cur) + k) % N_CH;
         for (int b = 0; b < N_CH; b++) begin
            if (!found && (b == idx) && mask[b]) begin
               res   = SEL_W'(b);
               found = 1'b1;
            end else begin
               found = found;
            end
         end
      end
      return res;
   endfunction

   // Enable bit of the channel currently on the output.
   always_comb begin
      cur_en_s = 1'b0;
      for (int b = 0; b < N_CH; b++) begin
         if (int'(cur_ch_q) == b) begin
            cur_en_s = en_mask_i[b];
         end else begin
            cur_en_s = cur_en_s;
         end
      end
   end

   // Channel selection, dwell counter and flag next-state, in priority order.
   always_comb begin
      nxt_ch_s  = cur_ch_q;
      dwell_d   = dwell_q;
      all_off_d = 1'b0;
      if (!mode_i) begin
         if (int'(sel_i) < N_CH) begin
            nxt_ch_s = sel_i;
         end else begin
            nxt_ch_s = cur_ch_q;
         end
         dwell_d = {DCNT_W{1'b0}};
      end else if (en_mask_i == {N_CH{1'b0}}) begin
         all_off_d = 1'b1;
      end else if (hold_i) begin
         nxt_ch_s = cur_ch_q;
      end else if (!cur_en_s) begin
         // Current channel was masked out: leave it immediately.
         nxt_ch_s = next_enabled(cur_ch_q, en_mask_i);
         dwell_d  = {DCNT_W{1'b0}};
      end else if (dwell_q == DWELL_LAST) begin
         nxt_ch_s = next_enabled(cur_ch_q, en_mask_i);
         dwell_d  = {DCNT_W{1'b0}};
      end else begin
         dwell_d = dwell_q + DCNT_W'(1);
      end
   end

   // Output data follows the next channel so dout always matches cur_ch.
   always_comb begin
      dout_d = {WIDTH{1'b0}};
      for (int k = 0; k < N_CH; k++) begin
         if (!all_off_d && (int'(nxt_ch_s) == k)) begin
            dout_d = din_i[k*WIDTH +: WIDTH];
         end else begin
            dout_d = dout_d;
         end
      end
      ch_change_d = (nxt_ch_s != cur_ch_q);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         dout_q      <= {WIDTH{1'b0}};
         cur_ch_q    <= {SEL_W{1'b0}};
         ch_change_q <= 1'b0;
         all_off_q   <= 1'b0;
         dwell_q     <= {DCNT_W{1'b0}};
      end else begin
         dout_q      <= dout_d;
         cur_ch_q    <= nxt_ch_s;
         ch_change_q <= ch_change_d;
         all_off_q   <= all_off_d;
         dwell_q     <= dwell_d;
      end
   end

   assign dout_o      = dout_q;
   assign cur_ch_o    = cur_ch_q;
   assign ch_change_o = ch_change_q;
   assign all_off_o   = all_off_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_n
//   Scoreboard bench for mux_scan_n. u_dut0: N_CH=4, WIDTH=4, DWELL=3.
//   u_dut1: N_CH=3, SEL_W=2 for the out-of-range select case.
//   Expected outputs are queued when stimulus is applied, popped after the edge.
// -----------------------------------------------------------------------------
module tb_mux_scan_n;

   typedef struct {
      logic [1:0] ch;
      logic [3:0] dout;
      logic       chg;
      logic       off;
   } exp_t;

   exp_t sb0_q[$];
   exp_t sb1_q[$];

   logic        clk_s = 1'b0;
   int          n_checks_r = 0;
   int          n_errors_r = 0;

   // DUT0 stimulus/response
   logic        rst0_n_s;
   logic [15:0] din0_s;
   logic        mode0_s;
   logic [1:0]  sel0_s;
   logic [3:0]  en0_s;
   logic        hold0_s;
   logic [3:0]  dout0_s;
   logic [1:0]  cur0_s;
   logic        chg0_s;
   logic        off0_s;

   // DUT1 stimulus/response
   logic        rst1_n_s;
   logic [11:0] din1_s;
   logic        mode1_s;
   logic [1:0]  sel1_s;
   logic [2:0]  en1_s;
   logic        hold1_s;
   logic [3:0]  dout1_s;
   logic [1:0]  cur1_s;
   logic        chg1_s;
   logic        off1_s;

   logic [3:0]  ch_val[4];

   always #5 clk_s = ~clk_s;

   mux_scan_n #(.N_CH(4), .WIDTH(4), .SEL_W(2), .DWELL(3)) u_dut0 (
      .clk_i(clk_s), .rst_ni(rst0_n_s), .din_i(din0_s), .mode_i(mode0_s),
      .sel_i(sel0_s), .en_mask_i(en0_s), .hold_i(hold0_s), .dout_o(dout0_s),
      .cur_ch_o(cur0_s), .ch_change_o(chg0_s), .all_off_o(off0_s)
   );

   mux_scan_n #(.N_CH(3), .WIDTH(4), .SEL_W(2), .DWELL(3)) u_dut1 (
      .clk_i(clk_s), .rst_ni(rst1_n_s), .din_i(din1_s), .mode_i(mode1_s),
      .sel_i(sel1_s), .en_mask_i(en1_s), .hold_i(hold1_s), .dout_o(dout1_s),
      .cur_ch_o(cur1_s), .ch_change_o(chg1_s), .all_off_o(off1_s)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks_r++;
      if (obs !== exp) begin
         n_errors_r++;
         $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Queue the expectation for DUT0, clock once, then compare.
   task automatic step0(input string tag, input logic [1:0] ch, input logic [3:0] d,
                        input logic chg, input logic off);
      exp_t e;
      e.ch = ch; e.dout = d; e.chg = chg; e.off = off;
      sb0_q.push_back(e);
      @(posedge clk_s);
      #1;
      e = sb0_q.pop_front();
      check_eq({tag, ".cur_ch"},    {30'd0, cur0_s},  {30'd0, e.ch});
      check_eq({tag, ".dout"},      {28'd0, dout0_s}, {28'd0, e.dout});
      check_eq({tag, ".ch_change"}, {31'd0, chg0_s},  {31'd0, e.chg});
      check_eq({tag, ".all_off"},   {31'd0, off0_s},  {31'd0, e.off});
   endtask

   task automatic step1(input string tag, input logic [1:0] ch, input logic [3:0] d,
                        input logic chg, input logic off);
      exp_t e;
      e.ch = ch; e.dout = d; e.chg = chg; e.off = off;
      sb1_q.push_back(e);
      @(posedge clk_s);
      #1;
      e = sb1_q.pop_front();
      check_eq({tag, ".cur_ch"},    {30'd0, cur1_s},  {30'd0, e.ch});
      check_eq({tag, ".dout"},      {28'd0, dout1_s}, {28'd0, e.dout});
      check_eq({tag, ".ch_change"}, {31'd0, chg1_s},  {31'd0, e.chg});
      check_eq({tag, ".all_off"},   {31'd0, off1_s},  {31'd0, e.off});
   endtask

   initial begin
      logic [1:0] ch;
      ch_val[0] = 4'hA; ch_val[1] = 4'hB; ch_val[2] = 4'hC; ch_val[3] = 4'hD;
      din0_s = 16'hDCBA; mode0_s = 1'b0; sel0_s = 2'd0; en0_s = 4'h0;
      hold0_s = 1'b0; rst0_n_s = 1'b0;
      din1_s = 12'hCBA; mode1_s = 1'b0; sel1_s = 2'd0; en1_s = 3'h0;
      hold1_s = 1'b0; rst1_n_s = 1'b0;

      // 1. reset and manual select
      step0("rst0", 2'd0, 4'h0, 1'b0, 1'b0);
      step0("rst1", 2'd0, 4'h0, 1'b0, 1'b0);
      rst0_n_s = 1'b1; sel0_s = 2'd2;
      step0("man_sel2", 2'd2, 4'hC, 1'b1, 1'b0);
      step0("man_sel2_hold", 2'd2, 4'hC, 1'b0, 1'b0);
      sel0_s = 2'd3;
      step0("man_sel3", 2'd3, 4'hD, 1'b1, 1'b0);
      sel0_s = 2'd0;
      step0("man_sel0", 2'd0, 4'hA, 1'b1, 1'b0);

      // 2. full scan, dwell 3, wrap after 12 edges
      mode0_s = 1'b1; en0_s = 4'hF;
      for (int i = 0; i < 12; i++) begin
         ch = 2'(((i + 1) / 3) % 4);
         step0($sformatf("scan%0d", i), ch, ch_val[ch], ((i + 1) % 3) == 0, 1'b0);
      end

      // 3. mask skip: ch0 disabled -> immediate advance, then 1,3,1,3
      en0_s = 4'b1010;
      step0("skip_force", 2'd1, 4'hB, 1'b1, 1'b0);
      for (int j = 1; j <= 9; j++) begin
         ch = ((j / 3) % 2 == 0) ? 2'd1 : 2'd3;
         step0($sformatf("skip%0d", j), ch, ch_val[ch], (j % 3) == 0, 1'b0);
      end

      // 4. hold at dwell_cnt=1 on ch3, din change seen through hold
      en0_s = 4'hF;
      step0("pre_hold", 2'd3, 4'hD, 1'b0, 1'b0);
      hold0_s = 1'b1;
      step0("hold1", 2'd3, 4'hD, 1'b0, 1'b0);
      step0("hold2", 2'd3, 4'hD, 1'b0, 1'b0);
      din0_s = 16'h7CBA;
      step0("hold3_din7", 2'd3, 4'h7, 1'b0, 1'b0);
      step0("hold4", 2'd3, 4'h7, 1'b0, 1'b0);
      step0("hold5", 2'd3, 4'h7, 1'b0, 1'b0);
      hold0_s = 1'b0;
      step0("unhold_stay", 2'd3, 4'h7, 1'b0, 1'b0);
      din0_s = 16'hDCBA;
      step0("unhold_adv", 2'd0, 4'hA, 1'b1, 1'b0);
      step0("pre_off", 2'd0, 4'hA, 1'b0, 1'b0);
      en0_s = 4'h0;
      step0("off1", 2'd0, 4'h0, 1'b0, 1'b1);
      step0("off2", 2'd0, 4'h0, 1'b0, 1'b1);
      en0_s = 4'hF;
      step0("resume", 2'd0, 4'hA, 1'b0, 1'b0);
      step0("resume_adv", 2'd1, 4'hB, 1'b1, 1'b0);

      // 5. reset mid-scan at ch2, dwell_cnt=1
      step0("to2_a", 2'd1, 4'hB, 1'b0, 1'b0);
      step0("to2_b", 2'd1, 4'hB, 1'b0, 1'b0);
      step0("to2_c", 2'd2, 4'hC, 1'b1, 1'b0);
      step0("to2_d", 2'd2, 4'hC, 1'b0, 1'b0);
      rst0_n_s = 1'b0;
      step0("mid_rst", 2'd0, 4'h0, 1'b0, 1'b0);
      rst0_n_s = 1'b1;
      step0("post_rst", 2'd0, 4'hA, 1'b0, 1'b0);
      // scan -> manual: sel takes effect on first manual edge
      mode0_s = 1'b0; sel0_s = 2'd3;
      step0("scan_to_man", 2'd3, 4'hD, 1'b1, 1'b0);

      // N_CH=3: out-of-range select ignored
      step1("n3_rst", 2'd0, 4'h0, 1'b0, 1'b0);
      rst1_n_s = 1'b1; sel1_s = 2'd1;
      step1("n3_sel1", 2'd1, 4'hB, 1'b1, 1'b0);
      sel1_s = 2'd3;
      step1("n3_sel3_a", 2'd1, 4'hB, 1'b0, 1'b0);
      step1("n3_sel3_b", 2'd1, 4'hB, 1'b0, 1'b0);
      sel1_s = 2'd2;
      step1("n3_sel2", 2'd2, 4'hC, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks_r, n_errors_r);
      $finish;
   end

endmodule
